// File: rtl/isp_pkg.sv
// isp_pkg: colour/mode codes, tag widths and gain constants shared by the ISP block.
package isp_pkg;
  localparam int COLOR_BIT_CNT = 2;
  localparam int MODE_BIT_CNT = 1;
  localparam logic [COLOR_BIT_CNT-1:0] VOID = 2'd0, RED = 2'd1, GREEN = 2'd2, BLUE = 2'd3;
  localparam logic [MODE_BIT_CNT-1:0] STAGE14 = 1'b0, STAGE56 = 1'b1;
  localparam int GAIN_UNITY = 64;
  localparam int GAIN_MAX = 255;
endpackage

// File: rtl/isp_gain_div.sv
// isp_gain_div: restoring unsigned divider, one quotient bit per cycle.
// The quotient saturates to GAIN_MAX, which also covers a zero divisor.
module isp_gain_div import isp_pkg::*; #(
  parameter int NUM_W = 14,
  parameter int DEN_W = 8,
  parameter int Q_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [Q_W-1:0]   quot_o
);
  localparam int CW = $clog2(NUM_W + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_W - 1);
  logic busy_q, done_q, ge;
  logic [CW-1:0] cnt_q;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W:0] rem_q, rem_d, shf;
  logic [DEN_W-1:0] den_q;
  logic [Q_W-1:0] res_q;
  always_comb begin
    shf = {rem_q[DEN_W-1:0], quo_q[NUM_W-1]};
    ge = shf >= {1'b0, den_q};
    rem_d = ge ? shf - {1'b0, den_q} : shf;
    quo_d = {quo_q[NUM_W-2:0], ge};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      res_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= num_i;
      rem_q <= '0;
      den_q <= den_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
      done_q <= cnt_q == LAST;
      busy_q <= cnt_q != LAST;
      if (cnt_q == LAST)
        res_q <= (den_q == '0 || quo_d > NUM_W'(GAIN_MAX)) ? Q_W'(GAIN_MAX) : quo_d[Q_W-1:0];
    end else
      done_q <= 1'b0;
  assign done_o = done_q;
  assign quot_o = res_q;
endmodule

// File: rtl/isp_top.sv
// isp_top: RGGB demosaic + gray-world gain estimation (STAGE14), gain + gamma (STAGE56).
// Define ISP_GAMMA_EN to apply the piecewise gamma curve; otherwise stage 2 is a plain register.
module isp_top import isp_pkg::*; #(
  parameter int IMG_COL = 1024,
  parameter int IMG_ROW = 1024,
  parameter int COLOR_DEPTH = 8,
  parameter int GAIN_BIT_CNT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COLOR_DEPTH-1:0]   pixel_in,
  input  logic                     valid_in,
  input  logic [COLOR_BIT_CNT-1:0] color_in,
  input  logic                     last_col_in,
  input  logic                     last_pic_in,
  input  logic [MODE_BIT_CNT-1:0]  mode_in,
  output logic [COLOR_DEPTH-1:0]   pixel_out,
  output logic                     valid_out,
  output logic [COLOR_BIT_CNT-1:0] color_out,
  output logic                     last_col_out,
  output logic                     last_pic_out,
  output logic                     finish_operation
);
  localparam int QC = IMG_COL / 2;
  localparam int LOGN = $clog2((IMG_ROW / 2) * QC);
  localparam int SW = COLOR_DEPTH + LOGN;
  localparam int CW = $clog2(IMG_COL);
  localparam int RW = $clog2(IMG_ROW);
  localparam int PW = COLOR_DEPTH + GAIN_BIT_CNT;
  localparam logic [1:0] G_IDLE = 2'd0, G_DIVR = 2'd1, G_DIVB = 2'd2, G_FIN = 2'd3;
  logic [MODE_BIT_CNT-1:0] mode_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [1:0] ph_q, gst_q;
  logic start_q, fin_q, lc_q, lp_q, div_done;
  logic [COLOR_DEPTH-1:0] lb_q [QC][2];
  logic [COLOR_DEPTH-1:0] g1_q, g_q, b_q, r_v, g_v, mean_r, mean_g, mean_b;
  logic [COLOR_DEPTH:0] gsum;
  logic [SW-1:0] sum_r_q, sum_g_q, sum_b_q;
  logic [GAIN_BIT_CNT-1:0] gain_r_q, gain_b_q, gain_c, quot;
  logic [PW-1:0] prod;
  logic [COLOR_DEPTH-1:0] p_v, s1_p_q, gam, po_q, po_d;
  logic [COLOR_BIT_CNT-1:0] s1_c_q, co_q, co_d;
  logic s1_v_q, s1_lc_q, s1_lp_q, vo_q, vo_d, lco_q, lco_d, lpo_q, lpo_d;
  logic chg, s14, fire, col_last, row_last;
  assign chg = mode_in != mode_q;
  assign s14 = valid_in && mode_in == STAGE14 && !chg;
  assign col_last = col_q == CW'(IMG_COL - 1);
  assign row_last = row_q == RW'(IMG_ROW - 1);
  assign fire = s14 && row_q[0] && col_q[0];
  assign r_v = lb_q[col_q[CW-1:1]][0];
  assign gsum = {1'b0, lb_q[col_q[CW-1:1]][1]} + {1'b0, g1_q};
  assign g_v = gsum[COLOR_DEPTH:1];
  assign mean_r = sum_r_q[SW-1:LOGN];
  assign mean_g = sum_g_q[SW-1:LOGN];
  assign mean_b = sum_b_q[SW-1:LOGN];
  assign gain_c = color_in == RED ? gain_r_q : color_in == BLUE ? gain_b_q : GAIN_BIT_CNT'(GAIN_UNITY);
  assign prod = PW'(pixel_in) * PW'(gain_c);
  assign p_v = |prod[PW-1:COLOR_DEPTH+6] ? '1 : prod[COLOR_DEPTH+5:6];
`ifdef ISP_GAMMA_EN
  assign gam = s1_p_q < COLOR_DEPTH'(64) ? {s1_p_q[COLOR_DEPTH-2:0], 1'b0} :
               s1_p_q < COLOR_DEPTH'(128) ? s1_p_q + COLOR_DEPTH'(64) : (s1_p_q >> 1) + COLOR_DEPTH'(128);
`else
  assign gam = s1_p_q;
`endif
  isp_gain_div #(.NUM_W(COLOR_DEPTH + 6), .DEN_W(COLOR_DEPTH), .Q_W(GAIN_BIT_CNT)) u_div (
    .clk(clk), .rst(rst), .start_i(start_q), .num_i({mean_g, 6'b0}),
    .den_i(gst_q == G_DIVR ? mean_r : mean_b), .done_o(div_done), .quot_o(quot)
  );
  // The line buffer holds the even row (R at slot 0, G at slot 1) and needs no reset.
  always_ff @(posedge clk)
    if (s14 && !row_q[0]) lb_q[col_q[CW-1:1]][col_q[0]] <= pixel_in;
  always_comb begin
    vo_d = 1'b0;
    po_d = po_q;
    co_d = VOID;
    lco_d = 1'b0;
    lpo_d = 1'b0;
    if (mode_in == STAGE56) begin
      vo_d = s1_v_q;
      po_d = gam;
      co_d = s1_v_q ? s1_c_q : VOID;
      lco_d = s1_v_q && s1_lc_q;
      lpo_d = s1_v_q && s1_lp_q;
    end else if (fire) begin
      vo_d = 1'b1;
      po_d = r_v;
      co_d = RED;
    end else if (ph_q != 2'd0) begin
      vo_d = 1'b1;
      po_d = ph_q == 2'd1 ? g_q : b_q;
      co_d = ph_q == 2'd1 ? GREEN : BLUE;
      lco_d = ph_q == 2'd2 && lc_q;
      lpo_d = ph_q == 2'd2 && lp_q;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= STAGE14;
      col_q <= '0;
      row_q <= '0;
      ph_q <= '0;
      gst_q <= G_IDLE;
      start_q <= 1'b0;
      fin_q <= 1'b0;
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
      g1_q <= '0;
      g_q <= '0;
      b_q <= '0;
      lc_q <= 1'b0;
      lp_q <= 1'b0;
      gain_r_q <= GAIN_BIT_CNT'(GAIN_UNITY);
      gain_b_q <= GAIN_BIT_CNT'(GAIN_UNITY);
      s1_v_q <= 1'b0;
      s1_p_q <= '0;
      s1_c_q <= VOID;
      s1_lc_q <= 1'b0;
      s1_lp_q <= 1'b0;
      vo_q <= 1'b0;
      po_q <= '0;
      co_q <= VOID;
      lco_q <= 1'b0;
      lpo_q <= 1'b0;
    end else begin
      mode_q <= mode_in;
      s1_v_q <= valid_in && mode_in == STAGE56 && !chg && color_in != VOID;
      s1_p_q <= p_v;
      s1_c_q <= color_in;
      s1_lc_q <= last_col_in;
      s1_lp_q <= last_pic_in;
      vo_q <= vo_d;
      po_q <= po_d;
      co_q <= co_d;
      lco_q <= lco_d;
      lpo_q <= lpo_d;
      start_q <= 1'b0;
      if (chg) begin
        col_q <= '0;
        row_q <= '0;
        ph_q <= '0;
        gst_q <= G_IDLE;
        fin_q <= 1'b0;
        sum_r_q <= '0;
        sum_g_q <= '0;
        sum_b_q <= '0;
      end else begin
        if (s14) begin
          col_q <= col_last ? '0 : col_q + CW'(1);
          if (col_last) row_q <= row_last ? '0 : row_q + RW'(1);
          if (row_q[0] && !col_q[0]) g1_q <= pixel_in;
        end
        ph_q <= fire ? 2'd1 : ph_q == 2'd1 ? 2'd2 : 2'd0;
        if (fire) begin
          g_q <= g_v;
          b_q <= pixel_in;
          lc_q <= col_last;
          lp_q <= col_last && row_last;
          sum_r_q <= sum_r_q + SW'(r_v);
          sum_g_q <= sum_g_q + SW'(g_v);
          sum_b_q <= sum_b_q + SW'(pixel_in);
          if (col_last && row_last) begin
            gst_q <= G_DIVR;
            start_q <= 1'b1;
          end
        end
        // Divide R first, then B; means are read live from the sum registers.
        if (div_done && gst_q == G_DIVR) begin
          gain_r_q <= quot;
          gst_q <= G_DIVB;
          start_q <= 1'b1;
        end
        if (div_done && gst_q == G_DIVB) begin
          gain_b_q <= quot;
          gst_q <= G_FIN;
        end
        if (gst_q == G_FIN) begin
          fin_q <= 1'b1;
          gst_q <= G_IDLE;
          sum_r_q <= '0;
          sum_g_q <= '0;
          sum_b_q <= '0;
        end
        if (mode_in == STAGE56 && vo_q && lpo_q) fin_q <= 1'b1;
      end
    end
  assign pixel_out = po_q;
  assign valid_out = vo_q;
  assign color_out = co_q;
  assign last_col_out = lco_q;
  assign last_pic_out = lpo_q;
  assign finish_operation = fin_q;
endmodule

// File: tb/tb_isp_top.sv
// tb_isp_top: directed scoreboard bench for isp_top on a 4x2 raw frame.
module tb_isp_top;
  import isp_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] pixel_in = '0;
  logic valid_in = 1'b0, last_col_in = 1'b0, last_pic_in = 1'b0, mode_in = 1'b0;
  logic [1:0] color_in = '0;
  logic [7:0] pixel_out;
  logic valid_out, last_col_out, last_pic_out, finish_operation;
  logic [1:0] color_out;
  int checks = 0, failures = 0, cyc = 0, gr = 64, gb = 64;
  typedef struct { int cyc; logic [7:0] pix; logic [1:0] col; logic lc; logic lp; } exp_t;
  exp_t sb[$];
  exp_t e;
  isp_top #(.IMG_COL(4), .IMG_ROW(2), .COLOR_DEPTH(8), .GAIN_BIT_CNT(8)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in), .color_in(color_in),
    .last_col_in(last_col_in), .last_pic_in(last_pic_in), .mode_in(mode_in),
    .pixel_out(pixel_out), .valid_out(valid_out), .color_out(color_out),
    .last_col_out(last_col_out), .last_pic_out(last_pic_out), .finish_operation(finish_operation)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] gm(input int p);
`ifdef ISP_GAMMA_EN
    return 8'(p < 64 ? 2 * p : p < 128 ? p + 64 : p / 2 + 128);
`else
    return 8'(p);
`endif
  endfunction
  function automatic int sc(input int x, input int g);
    return (x * g / 64 > 255) ? 255 : x * g / 64;
  endfunction
  function automatic int gcalc(input int mg, input int mc);
    return (mc == 0 || mg * 64 / mc > 255) ? 255 : mg * 64 / mc;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask
  task automatic put(input int pix, input logic [1:0] col, input logic lc, input logic lp);
    @(posedge clk); #1;
    pixel_in = 8'(pix); color_in = col; last_col_in = lc; last_pic_in = lp; valid_in = 1'b1;
  endtask
  task automatic gap();
    @(posedge clk); #1;
    valid_in = 1'b0; last_col_in = 1'b0; last_pic_in = 1'b0;
  endtask
  task automatic rgb(input int pix, input logic [1:0] col, input logic lc, input logic lp);
    int g;
    g = col == RED ? gr : col == BLUE ? gb : 64;
    put(pix, col, lc, lp);
    if (col != VOID) sb.push_back('{cyc + 2, gm(sc(pix, g)), col, lc, lp});
    gap();
  endtask
  task automatic frame14(input int r0 [4], input int r1 [4]);
    int sr, sg, sbl, g;
    sr = 0; sg = 0; sbl = 0;
    for (int c = 0; c < 4; c++) begin
      put(r0[c], VOID, c == 3, 1'b0);
      gap();
    end
    for (int c = 0; c < 4; c++) begin
      put(r1[c], VOID, c == 3, c == 3);
      if (c % 2 == 1) begin
        g = (r0[c] + r1[c-1]) / 2;
        sb.push_back('{cyc + 1, 8'(r0[c-1]), RED, 1'b0, 1'b0});
        sb.push_back('{cyc + 2, 8'(g), GREEN, 1'b0, 1'b0});
        sb.push_back('{cyc + 3, 8'(r1[c]), BLUE, c == 3, c == 3});
        sr += r0[c-1]; sg += g; sbl += r1[c];
      end
      gap();
    end
    gr = gcalc(sg / 2, sr / 2);
    gb = gcalc(sg / 2, sbl / 2);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
  endtask
  task automatic wait_fin(input string tag);
    for (int i = 0; i < 300 && finish_operation !== 1'b1; i++) @(posedge clk);
    #1;
    check(tag, finish_operation, 1);
  endtask
  task automatic set_mode(input logic m);
    mode_in = m;
    repeat (3) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) if (!rst && valid_out) begin
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL unexpected_beat got pix=%0d col=%0d", pixel_out, color_out);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert ({cyc, pixel_out, color_out, last_col_out, last_pic_out} === {e.cyc, e.pix, e.col, e.lc, e.lp}) else begin
        failures++;
        $error("FAIL beat got cyc=%0d pix=%0d col=%0d lc=%0b lp=%0b exp cyc=%0d pix=%0d col=%0d lc=%0b lp=%0b",
               cyc, pixel_out, color_out, last_col_out, last_pic_out, e.cyc, e.pix, e.col, e.lc, e.lp);
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {valid_out, pixel_out, color_out, last_col_out, last_pic_out, finish_operation}, 0);
    rst = 1'b0;
    set_mode(1'b1);
    put(100, RED, 1'b0, 1'b0);
    gap();
    @(posedge clk); #1;
    check("pre_rst_valid", valid_out, 1);
    rst = 1'b1;
    #1;
    check("rst_outs", {valid_out, pixel_out, color_out, last_col_out, last_pic_out, finish_operation}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rgb(100, RED, 1'b0, 1'b0);
    rgb(100, GREEN, 1'b0, 1'b0);
    rgb(100, BLUE, 1'b1, 1'b0);
    rgb(7, VOID, 1'b0, 1'b0);
    drain("drain_unity");
    check("fin_mid56", finish_operation, 0);
    rgb(100, RED, 1'b0, 1'b0);
    rgb(200, GREEN, 1'b0, 1'b0);
    rgb(50, BLUE, 1'b1, 1'b1);
    drain("drain_56a");
    check("fin_56a", finish_operation, 1);
    set_mode(1'b0);
    check("fin_clr14", finish_operation, 0);
    frame14('{40, 80, 40, 80}, '{80, 20, 80, 20});
    wait_fin("fin_14a");
    drain("drain_14a");
    set_mode(1'b1);
    check("fin_clr56", finish_operation, 0);
    rgb(40, RED, 1'b0, 1'b0);
    rgb(80, GREEN, 1'b0, 1'b0);
    rgb(20, BLUE, 1'b1, 1'b0);
    rgb(200, RED, 1'b0, 1'b0);
    rgb(80, GREEN, 1'b0, 1'b0);
    rgb(20, BLUE, 1'b1, 1'b1);
    drain("drain_56b");
    check("fin_56b", finish_operation, 1);
    set_mode(1'b0);
    frame14('{0, 81, 0, 81}, '{80, 20, 80, 20});
    wait_fin("fin_14b");
    drain("drain_14b");
    set_mode(1'b1);
    rgb(40, RED, 1'b0, 1'b0);
    rgb(81, GREEN, 1'b0, 1'b0);
    rgb(20, BLUE, 1'b1, 1'b1);
    drain("drain_56c");
    check("fin_56c", finish_operation, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/isp_top.md
Name: isp_top

Overview:
- Two-mode image-signal-processing block.
- Mode STAGE14 takes a raw RGGB Bayer frame, demosaics it to half-resolution RGB, accumulates per-channel statistics and derives gray-world white-balance gains.
- Mode STAGE56 takes an RGB stream, applies the stored gains and then a gamma curve.
- Sits between the sensor/frame interface and the downstream pixel sink; one colour sample moves per beat.

Parameters:
- IMG_COL, 1024, raw frame width in samples; even.
- IMG_ROW, 1024, raw frame height in rows; even. (IMG_ROW/2)*(IMG_COL/2) must be a power of two.
- COLOR_DEPTH, 8, bits per colour sample.
- GAIN_BIT_CNT, 8, gain width; unsigned Q2.6, so 64 = 1.0.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high).
- pixel_in  in  COLOR_DEPTH  input sample.
- valid_in  in  1  pixel_in/flags valid this cycle.
- color_in  in  2  colour tag: VOID=0, RED=1, GREEN=2, BLUE=3. Ignored in STAGE14.
- last_col_in  in  1  marks the last sample of a row.
- last_pic_in  in  1  marks the last sample of a frame.
- mode_in  in  1  STAGE14=0, STAGE56=1.
- pixel_out  out  COLOR_DEPTH  output sample.
- valid_out  out  1  output beat valid.
- color_out  out  2  tag of the output beat; never VOID when valid.
- last_col_out  out  1  last output pixel of a row; asserted on its BLUE beat.
- last_pic_out  out  1  last output pixel of a frame; asserted on its BLUE beat.
- finish_operation  out  1  level: current mode's frame is done.

Behaviour:
- Reset state:
  - All outputs 0.
  - gain_R = gain_G = gain_B = 64.
  - Column/row counters, channel sums and the divider all cleared.
  - Reset mid-frame aborts the operation completely.
- Mode handling:
  - mode_in is sampled every cycle.
  - Changing mode_in clears finish_operation and all counters.
  - Gains are kept across a mode change.
  - mode_in changes only between frames.
- Input rate: valid_in is never asserted on two consecutive cycles (at least one idle cycle between beats).
- STAGE14 input format:
  - Raw samples arrive row-major, IMG_COL per row.
  - Even rows are R,G,R,G…; odd rows are G,B,G,B….
  - An internal column counter tracks position; last_col_in and last_pic_in are informational only.
- STAGE14 demosaic:
  - One line buffer (IMG_COL/2 entries × 2 samples) holds the even row.
  - Each 2x2 quad yields one RGB pixel: R = R sample, G = floor((G0+G1)/2), B = B sample.
- STAGE14 output timing:
  - The quad completes on the odd-row, odd-column sample.
  - Output beats are RED, GREEN, BLUE on cycles +1, +2, +3 after that sample.
  - The next completing sample can arrive no earlier than +4.
  - last_col_out is set on the BLUE beat when the quad column is IMG_COL/2-1.
  - last_pic_out is set additionally when it is the last quad row.
- STAGE14 statistics:
  - Accumulate sum_R, sum_G, sum_B, each COLOR_DEPTH+log2(N) bits, where N = (IMG_ROW/2)*(IMG_COL/2).
  - After the final quad: mean_c = sum_c >> log2(N).
- STAGE14 gain computation:
  - Sequential restoring divider, 1 bit per cycle, runs R then B.
  - gain_R = min(255, (mean_G<<6)/mean_R); gain_B likewise using mean_B.
  - Divisor 0 gives gain 255.
  - gain_G = 64.
  - finish_operation rises the cycle after gain_B is stored and stays high until a mode change or reset.
- STAGE56 input/output:
  - Input beats arrive as RED, GREEN, BLUE triplets tagged by color_in; VOID beats are dropped.
  - Latency is 2 cycles, one beat out per beat in.
  - color_out, last_col_out and last_pic_out are the input tag/flags delayed 2 cycles.
- STAGE56 arithmetic:
  - Stage 1: p = (pixel_in * gain_c) >> 6, computed in 16 bits, floor, saturated to 255.
  - Stage 2: out = gamma(p).
  - Gamma curve: p<64 → 2p; p<128 → p+64; otherwise (p>>1)+128. The curve is continuous and 255 maps to 255.
- STAGE56 completion: finish_operation rises the cycle after the beat carrying last_pic_out is emitted.

Optional Feature:
- Macro: ISP_GAMMA_EN.
- Defined: stage 2 applies the piecewise gamma above.
- Undefined: stage 2 is a plain register (out = p); latency stays 2 cycles.

Decomposition:
- Package isp_pkg holds:
  - colour codes VOID/RED/GREEN/BLUE;
  - mode codes STAGE14/STAGE56;
  - widths COLOR_BIT_CNT=2, MODE_BIT_CNT=1;
  - GAIN_UNITY=64 and GAIN_MAX=255.
- One sub-module, isp_gain_div: sequential unsigned divider with start/done and saturation to GAIN_MAX.

Test Plan:
- Reset check: assert rst mid-beat → all outputs 0 immediately; a following STAGE56 triplet R=100,G=100,B=100 → 164,164,164 (unity gain).
- STAGE56 at unity: R=100,G=200,B=50 → out 164,228,100 on cycles +2; last_pic_out tagged on the final BLUE beat, then finish_operation=1.
- STAGE14 with IMG_COL=4, IMG_ROW=2:
  - Both quads R=40, G=80/80, B=20 → two pixels (40,80,20).
  - The second pixel carries last_col_out=1 and last_pic_out=1.
  - Result gain_R=128, gain_B=255 (saturated from 256); finish_operation=1.
- Follow-on STAGE56 frame: R=40,G=80,B=20 → 144,144,143. Saturation case: R=200 → 255.
- Green averaging and zero mean: G=81/80 → G out 80; all R samples 0 → gain_R=255.
- Gamma disabled (ISP_GAMMA_EN undefined): R=100 at unity gain → out 100, still 2-cycle latency.
